range_stream_sender: RTL and testbench

- Transmit side of the go/finish sample-stream protocol that the range-measurement block consumes.
- Upstream logic pushes samples into an internal FIFO and issues a burst command with a length.
- The block emits the burst as one go-marked first word, then middle words, then a finish-marked last word, followed by a mandatory idle gap.
- It computes the expected range of each burst locally so benches and on-chip self-check can compare against the receiver's result.

---
 rtl/range_stream_sender.sv | 175 +++++++++++++++++
 tb/tb_range_stream_sender.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/range_stream_sender.sv
// range_stream_sender: transmit side of the go/finish sample-stream protocol.
// Samples are queued in a small FIFO; a burst command sends `len` words as a
// go-marked first word, middle words and a finish-marked last word, then one
// idle GAP cycle that pulses done and publishes max-min of the burst.
//
// Handshakes: a push happens when wr_valid && wr_ready (wr_ready = FIFO not
// full). A burst command is accepted when start && start_ready (IDLE only).
// On the receive side there is no backpressure; a stall (FIFO empty mid-burst)
// holds data_out with go=finish=0, which cannot move the receiver's min/max.
module range_stream_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             start_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] exp_range,
  output logic             cmd_error,
  output logic [7:0]       stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head;

  // FSM and datapath registers
  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [WIDTH-1:0] min_q, max_q, data_q, exp_q;
  logic             go_q, finish_q, done_q, cmd_error_q;
  logic [7:0]       stall_q;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = wr_valid && !full;
  // rem_q == 0 in STREAM means the finish word is already on the wire.
  assign pop   = !empty && ((state_q == ST_ARM) ||
                            ((state_q == ST_STREAM) && (rem_q != '0)));

  assign wr_ready    = !full;
  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign data_out    = data_q;
  assign go          = go_q;
  assign finish      = finish_q;
  assign done        = done_q;
  assign exp_range   = exp_q;
  assign cmd_error   = cmd_error_q;
  assign stall_count = stall_q;

  // FIFO data write; storage needs no reset because count_q gates reads
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers and occupancy; a written word becomes visible next cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Burst sequencer with registered protocol outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      data_q      <= '0;
      exp_q       <= '0;
      go_q        <= 1'b0;
      finish_q    <= 1'b0;
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          go_q     <= 1'b0;
          finish_q <= 1'b0;
          data_q   <= '0;
          if (start) begin
            if (len < LEN_W'(2)) begin
              cmd_error_q <= 1'b1;
            end else begin
              rem_q   <= len;
              min_q   <= '0;
              max_q   <= '0;
              stall_q <= '0;
              state_q <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          finish_q <= 1'b0;
          if (!empty) begin
            data_q  <= head;
            go_q    <= 1'b1;
            min_q   <= head;
            max_q   <= head;
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= ST_STREAM;
          end else begin
            go_q   <= 1'b0;
            data_q <= '0;
          end
        end
        ST_STREAM: begin
          go_q <= 1'b0;
          if (rem_q == '0) begin
            finish_q <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b1;
            exp_q    <= max_q - min_q;
            state_q  <= ST_GAP;
          end else if (empty) begin
            finish_q <= 1'b0;
            if (stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
          end else begin
            data_q   <= head;
            finish_q <= (rem_q == LEN_W'(1));
            rem_q    <= rem_q - LEN_W'(1);
            if (head < min_q) min_q <= head;
            if (head > max_q) max_q <= head;
          end
        end
        default: begin
          go_q     <= 1'b0;
          finish_q <= 1'b0;
          data_q   <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_stream_sender.sv
// Directed bench for range_stream_sender with hand-computed expectations.
module tb_range_stream_sender;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LEN_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_ready;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             start_ready;
  logic [WIDTH-1:0] data_out;
  logic             go, finish, busy, done, cmd_error;
  logic [WIDTH-1:0] exp_range;
  logic [7:0]       stall_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  range_stream_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .len(len), .start_ready(start_ready),
    .data_out(data_out), .go(go), .finish(finish), .busy(busy), .done(done),
    .exp_range(exp_range), .cmd_error(cmd_error), .stall_count(stall_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [WIDTH-1:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic issue_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_start_ready", 32'(start_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_go", 32'(go), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_exp_range", 32'(exp_range), 0);

    // basic burst 3,9,1,7
    push_word(16'd3); push_word(16'd9); push_word(16'd1); push_word(16'd7);
    issue_start(8'd4);
    check("b1_arm_busy", 32'(busy), 1);
    check("b1_arm_go", 32'(go), 0);
    tick();
    check("b1_go", 32'(go), 1);
    check("b1_d0", 32'(data_out), 3);
    tick();
    check("b1_d1", 32'(data_out), 9);
    check("b1_d1_go", 32'(go), 0);
    tick();
    check("b1_d2", 32'(data_out), 1);
    check("b1_d2_fin", 32'(finish), 0);
    tick();
    check("b1_d3", 32'(data_out), 7);
    check("b1_fin", 32'(finish), 1);
    check("b1_fin_go", 32'(go), 0);
    tick();
    check("b1_done", 32'(done), 1);
    check("b1_gap_fin", 32'(finish), 0);
    check("b1_gap_data", 32'(data_out), 0);
    check("b1_range", 32'(exp_range), 8);
    check("b1_stall", 32'(stall_count), 0);
    check("b1_gap_start_ready", 32'(start_ready), 0);
    tick();
    check("b1_done_pulse", 32'(done), 0);
    check("b1_idle_busy", 32'(busy), 0);
    check("b1_range_hold", 32'(exp_range), 8);

    // rejected commands
    issue_start(8'd1);
    check("e1_cmd_error", 32'(cmd_error), 1);
    check("e1_busy", 32'(busy), 0);
    check("e1_start_ready", 32'(start_ready), 1);
    issue_start(8'd0);
    check("e0_cmd_error", 32'(cmd_error), 1);
    check("e0_go", 32'(go), 0);
    tick();
    check("e_cmd_error_clear", 32'(cmd_error), 0);
    check("e_busy", 32'(busy), 0);

    // stalled burst: len=3, pushes of 5/2/8 at cycles 4/7/10 after the start edge
    issue_start(8'd3);
    for (int c = 1; c <= 12; c++) begin
      wr_valid = (c == 4) || (c == 7) || (c == 10);
      wr_data  = (c == 4) ? 16'd5 : (c == 7) ? 16'd2 : 16'd8;
      tick();
      wr_valid = 1'b0;
      case (c)
        3:  begin check("s_arm_go", 32'(go), 0); check("s_arm_data", 32'(data_out), 0);
                  check("s_arm_busy", 32'(busy), 1); end
        5:  begin check("s_go", 32'(go), 1); check("s_d0", 32'(data_out), 5); end
        6:  begin check("s_hold", 32'(data_out), 5); check("s_hold_go", 32'(go), 0); end
        8:  check("s_d1", 32'(data_out), 2);
        9:  check("s_hold2", 32'(data_out), 2);
        11: begin check("s_d2", 32'(data_out), 8); check("s_fin", 32'(finish), 1); end
        12: begin check("s_done", 32'(done), 1); check("s_range", 32'(exp_range), 6);
                  check("s_stall", 32'(stall_count), 4); end
        default: ;
      endcase
    end
    tick();

    // full FIFO: 9 pushes, the 9th is dropped
    for (int i = 0; i < 9; i++) begin
      push_word(16'(10 + i));
      if (i < DEPTH) exp_q.push_back(16'(10 + i));
      if (i == DEPTH - 1) check("f_full", 32'(wr_ready), 0);
    end
    issue_start(8'd8);
    tick();
    check("f_go", 32'(go), 1);
    check("f_d0", 32'(data_out), 32'(exp_q.pop_front()));
    check("f_ready_after_pop", 32'(wr_ready), 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("f_dk", 32'(data_out), 32'(exp_q.pop_front()));
      check("f_fin", 32'(finish), (k == 7) ? 1 : 0);
    end
    tick();
    check("f_done", 32'(done), 1);
    check("f_range", 32'(exp_range), 7);
    tick();

    // reset mid-burst
    push_word(16'd20); push_word(16'd30); push_word(16'd40);
    issue_start(8'd3);
    tick();
    check("r_go", 32'(go), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_go0", 32'(go), 0);
    check("r_fin0", 32'(finish), 0);
    check("r_busy0", 32'(busy), 0);
    check("r_data0", 32'(data_out), 0);
    check("r_range0", 32'(exp_range), 0);
    check("r_wr_ready", 32'(wr_ready), 1);
    push_word(16'd11); push_word(16'd5);
    issue_start(8'd2);
    tick();
    check("r2_go", 32'(go), 1);
    check("r2_d0", 32'(data_out), 11);
    tick();
    check("r2_fin", 32'(finish), 1);
    check("r2_d1", 32'(data_out), 5);
    tick();
    check("r2_range", 32'(exp_range), 6);
    tick();

    // start held high across a len=2 burst
    push_word(16'd1); push_word(16'd4); push_word(16'd2); push_word(16'd9);
    start = 1'b1;
    len   = 8'd2;
    tick();
    tick();
    check("h_go", 32'(go), 1);
    check("h_d0", 32'(data_out), 1);
    tick();
    check("h_fin", 32'(finish), 1);
    check("h_d1", 32'(data_out), 4);
    tick();
    check("h_gap_go", 32'(go), 0);
    check("h_gap_done", 32'(done), 1);
    check("h_gap_start_ready", 32'(start_ready), 0);
    check("h_gap_cmd_error", 32'(cmd_error), 0);
    check("h_range", 32'(exp_range), 3);
    tick();
    check("h_idle_go", 32'(go), 0);
    check("h_idle_busy", 32'(busy), 0);
    tick();
    check("h_arm_go", 32'(go), 0);
    check("h_arm_busy", 32'(busy), 1);
    tick();
    start = 1'b0;
    check("h2_go", 32'(go), 1);
    check("h2_d0", 32'(data_out), 2);
    tick();
    check("h2_fin", 32'(finish), 1);
    check("h2_d1", 32'(data_out), 9);
    tick();
    check("h2_done", 32'(done), 1);
    check("h2_range", 32'(exp_range), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
